// File: rtl/shaft_encoder_monitor.sv
// Wheel shaft encoder monitor. Each side has a synchronizer, a debouncer, a tick counter and a period/stall FSM.
// A shared target FSM tracks a distance goal that both wheels must reach.

// State table (period FSM)
//   state | meaning
//   IDLE  | no reference tick yet, or the wheel stalled since the last tick
//   RUN   | timing the interval since the last tick
module shaft_encoder_side #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int STALL_CYCLES    = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse,
  input  logic        clear,
  output logic        tick,
  output logic [15:0] count,
  output logic [23:0] period,
  output logic        period_valid,
  output logic        stall
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {IDLE, RUN} per_state_e;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_cnt_inc;
  logic [15:0]   count_q, count_d;
  logic [23:0]   timer_q, timer_d, timer_sat;
  logic [24:0]   timer_inc;
  logic [23:0]   period_q, period_d;
  logic          valid_q, valid_d;
  logic          stall_q, stall_d;
  logic          tick_w;
  per_state_e    state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
      state_q    <= IDLE;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      deb_cnt_q  <= deb_cnt_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    sync1_d     = pulse;
    sync2_d     = sync1_q;
    deb_d       = deb_q;
    deb_cnt_d   = '0;
    deb_cnt_inc = deb_cnt_q + DW'(1);
    // Any sample that matches the accepted level restarts the stability count.
    if (sync2_q != deb_q) begin
      if (deb_cnt_inc == DW'(DEBOUNCE_CYCLES)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_inc;
      end
    end
    deb_prev_d = deb_q;
    tick_w     = deb_q & ~deb_prev_q;

    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick_w && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end

    timer_inc = {1'b0, timer_q} + 25'd1;
    timer_sat = timer_inc[24] ? 24'hFFFFFF : timer_inc[23:0];
    state_d   = state_q;
    timer_d   = timer_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    stall_d   = stall_q;
    case (state_q)
      IDLE: begin
        if (tick_w) begin
          state_d = RUN;
          timer_d = '0;
          stall_d = 1'b0;
        end
      end
      RUN: begin
        if (tick_w) begin
          period_d = timer_sat;
          valid_d  = 1'b1;
          timer_d  = '0;
          stall_d  = 1'b0;
        end else if (timer_inc == 25'(STALL_CYCLES)) begin
          stall_d  = 1'b1;
          period_d = '0;
          timer_d  = '0;
          state_d  = IDLE;
        end else begin
          timer_d = timer_sat;
        end
      end
    endcase
  end

  assign tick         = tick_w;
  assign count        = count_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign stall        = stall_q;

endmodule

// State table (target FSM)
//   state   | meaning
//   T_IDLE  | no target armed
//   T_ARMED | counting ticks toward the latched target
//   T_DONE  | both wheels reached the target; held until the next load
module shaft_encoder_monitor #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int STALL_CYCLES    = 12_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shaftPulseL,
  input  logic               shaftPulseR,
  input  logic               clearCount,
  input  logic               targetLoad,
  input  logic [15:0]        targetCount,
  output logic [15:0]        countL,
  output logic [15:0]        countR,
  output logic [23:0]        periodL,
  output logic [23:0]        periodR,
  output logic               periodValidL,
  output logic               periodValidR,
  output logic               stallL,
  output logic               stallR,
  output logic               targetDone,
  output logic signed [16:0] diffLR
);

  typedef enum logic [1:0] {T_IDLE, T_ARMED, T_DONE} tgt_state_e;

  logic        tick_l, tick_r;
  logic [15:0] target_q, target_d;
  logic [15:0] prog_l_q, prog_l_d, prog_r_q, prog_r_d;
  logic [16:0] diff_q, diff_d;
  tgt_state_e  t_state_q, t_state_d;

  shaft_encoder_side #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STALL_CYCLES   (STALL_CYCLES)
  ) u_side_l (
    .clk         (clk),
    .rst         (rst),
    .pulse       (shaftPulseL),
    .clear       (clearCount),
    .tick        (tick_l),
    .count       (countL),
    .period      (periodL),
    .period_valid(periodValidL),
    .stall       (stallL)
  );

  shaft_encoder_side #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STALL_CYCLES   (STALL_CYCLES)
  ) u_side_r (
    .clk         (clk),
    .rst         (rst),
    .pulse       (shaftPulseR),
    .clear       (clearCount),
    .tick        (tick_r),
    .count       (countR),
    .period      (periodR),
    .period_valid(periodValidR),
    .stall       (stallR)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q  <= '0;
      prog_l_q  <= '0;
      prog_r_q  <= '0;
      diff_q    <= '0;
      t_state_q <= T_IDLE;
    end else begin
      target_q  <= target_d;
      prog_l_q  <= prog_l_d;
      prog_r_q  <= prog_r_d;
      diff_q    <= diff_d;
      t_state_q <= t_state_d;
    end
  end

  always_comb begin
    target_d  = target_q;
    prog_l_d  = prog_l_q;
    prog_r_d  = prog_r_q;
    t_state_d = t_state_q;
    diff_d    = {1'b0, countL} - {1'b0, countR};
    // A load discards any tick in the same cycle by zeroing progress outright.
    if (targetLoad) begin
      target_d  = targetCount;
      prog_l_d  = '0;
      prog_r_d  = '0;
      t_state_d = T_ARMED;
    end else begin
      case (t_state_q)
        T_ARMED: begin
          if (tick_l && (prog_l_q != 16'hFFFF)) prog_l_d = prog_l_q + 16'd1;
          if (tick_r && (prog_r_q != 16'hFFFF)) prog_r_d = prog_r_q + 16'd1;
          if ((prog_l_d >= target_q) && (prog_r_d >= target_q)) t_state_d = T_DONE;
        end
        default: t_state_d = t_state_q;
      endcase
    end
  end

  assign targetDone = (t_state_q == T_DONE);
  assign diffLR     = diff_q;

endmodule

// File: tb/tb_shaft_encoder_monitor.sv
// Directed bench for shaft_encoder_monitor with short debounce and stall windows.
module tb_shaft_encoder_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        shaftPulseL, shaftPulseR, clearCount, targetLoad;
  logic [15:0] targetCount;
  logic [15:0] countL, countR;
  logic [23:0] periodL, periodR;
  logic        periodValidL, periodValidR, stallL, stallR, targetDone;
  logic signed [16:0] diffLR;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shaft_encoder_monitor #(
    .DEBOUNCE_CYCLES(4),
    .STALL_CYCLES   (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .shaftPulseL (shaftPulseL),
    .shaftPulseR (shaftPulseR),
    .clearCount  (clearCount),
    .targetLoad  (targetLoad),
    .targetCount (targetCount),
    .countL      (countL),
    .countR      (countR),
    .periodL     (periodL),
    .periodR     (periodR),
    .periodValidL(periodValidL),
    .periodValidR(periodValidR),
    .stallL      (stallL),
    .stallR      (stallR),
    .targetDone  (targetDone),
    .diffLR      (diffLR)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_countL"}, {16'd0, countL}, 32'd0);
    chk({tag, "_countR"}, {16'd0, countR}, 32'd0);
    chk({tag, "_periodL"}, {8'd0, periodL}, 32'd0);
    chk({tag, "_periodR"}, {8'd0, periodR}, 32'd0);
    chk({tag, "_validL"}, {31'd0, periodValidL}, 32'd0);
    chk({tag, "_validR"}, {31'd0, periodValidR}, 32'd0);
    chk({tag, "_stallL"}, {31'd0, stallL}, 32'd0);
    chk({tag, "_stallR"}, {31'd0, stallR}, 32'd0);
    chk({tag, "_done"}, {31'd0, targetDone}, 32'd0);
    chk({tag, "_diff"}, {15'd0, diffLR}, 32'd0);
  endtask

  // Clean pulse: tick lands 7 cycles after the rising pin edge, 20-cycle cadence.
  task automatic pulse(input bit right);
    if (right) shaftPulseR = 1'b1; else shaftPulseL = 1'b1;
    step(10);
    if (right) shaftPulseR = 1'b0; else shaftPulseL = 1'b0;
    step(10);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    shaftPulseL = 1'b0;
    shaftPulseR = 1'b0;
    clearCount  = 1'b0;
    targetLoad  = 1'b0;
    targetCount = 16'd0;
    step(3);
    chk_zero("reset");
    rst = 1'b0;
    step(1);

    // First L tick: exact latency, no period strobe from IDLE.
    shaftPulseL = 1'b1;
    step(6);
    chk("lat_countL_early", {16'd0, countL}, 32'd0);
    step(1);
    chk("lat_countL", {16'd0, countL}, 32'd1);
    chk("lat_validL", {31'd0, periodValidL}, 32'd0);
    step(1);
    chk("lat_validL_next", {31'd0, periodValidL}, 32'd0);
    step(12);
    shaftPulseL = 1'b0;
    step(20);

    for (int p = 1; p <= 3; p++) begin
      shaftPulseL = 1'b1;
      step(7);
      chk("per_periodL", {8'd0, periodL}, 32'd40);
      chk("per_validL", {31'd0, periodValidL}, 32'd1);
      chk("per_countL", {16'd0, countL}, 32'(1 + p));
      step(1);
      chk("per_validL_off", {31'd0, periodValidL}, 32'd0);
      step(12);
      shaftPulseL = 1'b0;
      step(20);
    end

    step(66);
    chk("stall_early", {31'd0, stallL}, 32'd0);
    chk("stall_early_period", {8'd0, periodL}, 32'd40);
    step(1);
    chk("stallL", {31'd0, stallL}, 32'd1);
    chk("stall_periodL", {8'd0, periodL}, 32'd0);

    // Short glitches on R never survive the debounce window.
    for (int i = 0; i < 5; i++) begin
      shaftPulseR = 1'b1;
      step(3);
      shaftPulseR = 1'b0;
      step(3);
    end
    step(10);
    chk("glitch_countR", {16'd0, countR}, 32'd0);
    chk("glitch_diff", {15'd0, diffLR}, 32'd4);

    // Target of 3 ticks per side.
    targetCount = 16'd3;
    targetLoad  = 1'b1;
    step(1);
    targetLoad  = 1'b0;
    chk("tgt_armed_done", {31'd0, targetDone}, 32'd0);
    pulse(1'b0);
    chk("tgt_stall_clear", {31'd0, stallL}, 32'd0);
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b1);
    pulse(1'b1);
    chk("tgt_partial_done", {31'd0, targetDone}, 32'd0);
    chk("tgt_countL", {16'd0, countL}, 32'd7);
    chk("tgt_countR", {16'd0, countR}, 32'd2);
    shaftPulseR = 1'b1;
    step(6);
    chk("tgt_pre_done", {31'd0, targetDone}, 32'd0);
    step(1);
    chk("tgt_done", {31'd0, targetDone}, 32'd1);
    chk("tgt_countR3", {16'd0, countR}, 32'd3);
    step(3);
    shaftPulseR = 1'b0;
    step(10);
    chk("tgt_done_hold", {31'd0, targetDone}, 32'd1);
    chk("tgt_diff", {15'd0, diffLR}, 32'd4);

    // clearCount leaves the target FSM alone.
    clearCount = 1'b1;
    step(1);
    clearCount = 1'b0;
    chk("clr_countL", {16'd0, countL}, 32'd0);
    chk("clr_countR", {16'd0, countR}, 32'd0);
    chk("clr_done_hold", {31'd0, targetDone}, 32'd1);
    for (int i = 0; i < 5; i++) pulse(1'b0);
    pulse(1'b1);
    pulse(1'b1);
    chk("pre_countL5", {16'd0, countL}, 32'd5);
    chk("pre_countR2", {16'd0, countR}, 32'd2);
    chk("pre_diff3", {15'd0, diffLR}, 32'd3);

    // clearCount coincident with an L tick: clear wins, diff follows a cycle later.
    shaftPulseL = 1'b1;
    step(6);
    clearCount = 1'b1;
    step(1);
    clearCount = 1'b0;
    chk("coin_countL", {16'd0, countL}, 32'd0);
    chk("coin_countR", {16'd0, countR}, 32'd0);
    chk("coin_diff_lag", {15'd0, diffLR}, 32'd3);
    step(1);
    chk("coin_diff", {15'd0, diffLR}, 32'd0);
    step(3);
    shaftPulseL = 1'b0;
    step(10);

    // Zero target completes one cycle after the load.
    targetCount = 16'd0;
    targetLoad  = 1'b1;
    step(1);
    targetLoad  = 1'b0;
    chk("zero_tgt_armed", {31'd0, targetDone}, 32'd0);
    step(1);
    chk("zero_tgt_done", {31'd0, targetDone}, 32'd1);

    // Reset mid-debounce while armed abandons both operations.
    targetCount = 16'd3;
    targetLoad  = 1'b1;
    step(1);
    targetLoad  = 1'b0;
    chk("rst_armed", {31'd0, targetDone}, 32'd0);
    shaftPulseL = 1'b1;
    step(4);
    rst = 1'b1;
    shaftPulseL = 1'b0;
    step(2);
    rst = 1'b0;
    chk_zero("rst_mid");
    step(20);
    chk("rst_no_tick", {16'd0, countL}, 32'd0);
    chk("rst_no_done", {31'd0, targetDone}, 32'd0);

    // Negative difference.
    pulse(1'b1);
    chk("neg_countR", {16'd0, countR}, 32'd1);
    chk("neg_diff", {15'd0, diffLR}, 32'h1FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shaft_encoder_monitor.md
SHAFT_ENCODER_MONITOR -- requirements
Module: shaft_encoder_monitor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 5000, meaning consecutive stable clk cycles required to accept a level change on a pulse input.
REQ-002 SHALL have parameter STALL_CYCLES, default 12_500_000, meaning clk cycles without a tick before a side is declared stalled.
REQ-003 SHALL have ports clk, input, 1, the single system clock (50 MHz).
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high, sampled on posedge clk.
REQ-005 SHALL have ports shaftPulseL and shaftPulseR, input, 1 each, asynchronous raw wheel shaft encoder pulses.
REQ-006 SHALL have port clearCount, input, 1, a one-cycle strobe that zeroes both tick counts.
REQ-007 SHALL have port targetLoad, input, 1, a one-cycle strobe that arms a distance target.
REQ-008 SHALL have port targetCount, input, 16, the tick target latched on targetLoad.
REQ-009 SHALL have ports countL and countR, output, 16 each, accumulated ticks per side.
REQ-010 SHALL have ports periodL and periodR, output, 24 each, clk cycles between the last two ticks per side.
REQ-011 SHALL have ports periodValidL and periodValidR, output, 1 each, one-cycle strobes on period update.
REQ-012 SHALL have ports stallL and stallR, output, 1 each, level outputs flagging a stopped wheel.
REQ-013 SHALL have port targetDone, output, 1, a level output flagging that the armed target has been reached.
REQ-014 SHALL have port diffLR, output, 17 signed, equal to countL minus countR.

Function
REQ-015 Each pulse input SHALL pass through a 2-flop synchronizer.
REQ-016 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate bounce restarts the count.
REQ-017 A tick SHALL be a 0-to-1 transition of the debounced level, asserted one cycle after that transition; the total pin-to-tick latency is 3+DEBOUNCE_CYCLES cycles.
REQ-018 countX SHALL increment by 1 on each tick and saturate at 16'hFFFF, with no wrap.
REQ-019 clearCount SHALL zero both counts on the next edge; clearCount coincident with a tick SHALL yield 0 (clear wins).
REQ-020 Each side SHALL run a period FSM with states IDLE (no reference tick) and RUN.
REQ-021 In IDLE, a tick SHALL move the FSM to RUN, zero the timer, and produce no periodValid strobe.
REQ-022 In RUN, the timer SHALL increment each cycle and saturate at 24'hFFFFFF.
REQ-023 In RUN, a tick SHALL load periodX with timer+1 (saturating), pulse periodValidX for one cycle, and zero the timer.
REQ-024 In RUN, timer+1 reaching STALL_CYCLES with no tick SHALL set stallX=1, set periodX=0, and return the FSM to IDLE.
REQ-025 stallX SHALL clear on the next tick.
REQ-026 The target FSM SHALL have states T_IDLE, T_ARMED, and T_DONE.
REQ-027 targetLoad SHALL latch targetCount, zero per-side progress counters (16-bit, saturating), and enter T_ARMED from any state.
REQ-028 In T_ARMED, progress counters SHALL count ticks.
REQ-029 T_ARMED SHALL move to T_DONE when both progress counters are greater than or equal to the target.
REQ-030 targetCount=0 SHALL reach T_DONE one cycle after the load.
REQ-031 targetDone SHALL be 1 only in T_DONE, holding until the next targetLoad or rst; clearCount does not affect the target FSM.
REQ-032 A tick coincident with targetLoad SHALL NOT count toward the new target.
REQ-033 diffLR SHALL be registered, equal to the sign-extended countL minus countR, with a one-cycle lag relative to the counts.

Reset
REQ-034 rst SHALL drive all outputs to 0: counts, periods, strobes, stall flags, targetDone, and diffLR.
REQ-035 rst SHALL put both period FSMs in IDLE and the target FSM in T_IDLE.
REQ-036 rst SHALL load each debounced level from its synchronizer output's reset value (0) and zero all timers.
REQ-037 rst asserted mid-debounce or mid-target SHALL abandon the operation with no tick or done emitted afterward.

Verification (DEBOUNCE_CYCLES=4, STALL_CYCLES=100)
REQ-038 A clean rising edge on shaftPulseL held 20 cycles -> a tick exactly 7 cycles after the pin edge, countL=1, no periodValidL strobe.
REQ-039 Glitches high for 3 cycles repeated 5 times on shaftPulseR -> countR stays 0.
REQ-040 Pulses every 40 cycles on L after the first tick -> periodL=40 with a periodValidL strobe per tick; stopping pulses -> stallL=1 and periodL=0 exactly 100 cycles after the last tick.
REQ-041 targetLoad with targetCount=3, then L gets 3 ticks and R gets 2 ticks -> targetDone=0; a third R tick -> targetDone=1 on the next cycle, holding high.
REQ-042 countL=5, countR=2, then clearCount coincident with an L tick -> countL=0, countR=0, and diffLR=0 one cycle later.
REQ-043 rst asserted at 2 cycles into the debounce window and while T_ARMED -> all outputs 0, no later tick, targetDone=0.
